// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared slice width and FSM state encoding
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - combinational 4-bit adder slice driven by the serial controller
module fulladder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Plain 4-bit add with carry in/out.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle wide adder sequencing one 4-bit slice
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SLICE_W*NIBBLES-1:0] op_a,
    input  logic [SLICE_W*NIBBLES-1:0] op_b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                       cout,
    output logic [SLICE_W-1:0]         add_a,
    output logic [SLICE_W-1:0]         add_b,
    output logic                       add_ci,
    input  logic [SLICE_W-1:0]         add_s,
    input  logic                       add_co
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_reg, b_reg, work_q, sum_q, sum_next;
    logic             cout_q;

    // Next-state logic: accept start only when not running, leave RUN after the top nibble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Final result: nibbles collected so far with the slice output in the top position.
    always_comb begin
        sum_next = work_q;
        sum_next[W-SLICE_W +: SLICE_W] = add_s;
    end

    // Datapath: latch operands on start, then collect one slice result per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        carry_q <= cin;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    work_q[{idx_q, 2'b00} +: SLICE_W] <= add_s;
                    carry_q <= add_co;
                    if (idx_q == LAST_IDX) begin
                        sum_q  <= sum_next;
                        cout_q <= add_co;
                        idx_q  <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Slice inputs come from the latched operands only, so live operand changes are harmless.
    always_comb begin
        add_a  = a_reg[{idx_q, 2'b00} +: SLICE_W];
        add_b  = b_reg[{idx_q, 2'b00} +: SLICE_W];
        add_ci = carry_q;
        busy   = (state_q == ST_RUN);
        done   = (state_q == ST_DONE);
        sum    = sum_q;
        cout   = cout_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and random checks of the serial adder against plain arithmetic
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cin;
    logic [W-1:0] op_a, op_b, sum;
    logic         busy, done, cout;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_ci, add_co;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] held_sum;
    logic         held_cout;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    fulladder u_slice (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition from IDLE; optionally pokes start/op_a during RUN to show they are ignored.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input bit poke);
        logic [W:0] ref_v;
        ref_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < NIBBLES; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("add_a", add_a, (a >> (4 * i)) & 16'h000F);
            check("add_b", add_b, (b >> (4 * i)) & 16'h000F);
            if (i == 0) check("add_ci0", add_ci, c);
            check("sum_held", sum, held_sum);
            check("cout_held", cout, held_cout);
            if (poke && i == 1) begin
                start = 1'b1;
                op_a  = 16'hFFFF;
            end
            if (poke && i == 2) start = 1'b0;
            tick();
        end
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("sum", sum, ref_v[W-1:0]);
        check("cout", cout, ref_v[W]);
        held_sum  = ref_v[W-1:0];
        held_cout = ref_v[W];
        tick();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_ci", add_ci, 0);
        held_sum  = '0;
        held_cout = 1'b0;

        run_add(16'h000B, 16'h0003, 1'b0, 1'b0);
        run_add(16'h000B, 16'h0003, 1'b1, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_add(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_add(16'h1234, 16'h4321, 1'b0, 1'b1);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        // Reset during the second RUN cycle aborts with no done pulse.
        op_a  = 16'hABCD;
        op_b  = 16'h1111;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_add_a", add_a, 0);
        held_sum  = '0;
        held_cout = 1'b0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end

        // Start held through DONE: the second operation is accepted immediately.
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        op_a = 16'h8000;
        op_b = 16'h8000;
        for (int i = 0; i < NIBBLES; i++) begin
            check("b2b_busy1", busy, 1);
            tick();
        end
        check("b2b_done1", done, 1);
        check("b2b_sum1", sum, 16'h5555);
        check("b2b_cout1", cout, 0);
        tick();
        start = 1'b0;
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_done", done, 0);
        for (int i = 0; i < NIBBLES; i++) begin
            check("b2b_busy2", busy, 1);
            check("b2b_sum_held", sum, 16'h5555);
            tick();
        end
        check("b2b_done2", done, 1);
        check("b2b_sum2", sum, 16'h0000);
        check("b2b_cout2", cout, 1);
        held_sum  = 16'h0000;
        held_cout = 1'b1;
        tick();
        check("b2b_done_pulse", done, 0);

        for (int n = 0; n < 24; n++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
